// File: rtl/complex_nr_mult_if.sv
// ----------------------------------------------------------------------------
// complex_nr_mult_if
// Groups the operand and result handshakes of the complex multiplier.
//
//   op_val / op_ready        operand handshake (producer -> multiplier)
//   op_1_re, op_1_im         operand 1, signed DATA_WIDTH
//   op_2_re, op_2_im         operand 2, signed DATA_WIDTH
//   res_val / res_ready      result handshake (multiplier -> consumer)
//   res_re, res_im           result, signed 2*DATA_WIDTH+1
//
// Modports:
//   master  : operand producer / result consumer side
//   slave   : the multiplier itself
// ----------------------------------------------------------------------------
interface complex_nr_mult_if #(
    parameter int DATA_WIDTH = 8
);
    logic                          op_val;
    logic                          op_ready;
    logic signed [DATA_WIDTH-1:0]  op_1_re;
    logic signed [DATA_WIDTH-1:0]  op_1_im;
    logic signed [DATA_WIDTH-1:0]  op_2_re;
    logic signed [DATA_WIDTH-1:0]  op_2_im;
    logic                          res_val;
    logic                          res_ready;
    logic signed [2*DATA_WIDTH:0]  res_re;
    logic signed [2*DATA_WIDTH:0]  res_im;

    modport master (
        output op_val,
        output op_1_re,
        output op_1_im,
        output op_2_re,
        output op_2_im,
        output res_ready,
        input  op_ready,
        input  res_val,
        input  res_re,
        input  res_im
    );

    modport slave (
        input  op_val,
        input  op_1_re,
        input  op_1_im,
        input  op_2_re,
        input  op_2_im,
        input  res_ready,
        output op_ready,
        output res_val,
        output res_re,
        output res_im
    );
endinterface

// File: rtl/complex_nr_mult.sv
// ----------------------------------------------------------------------------
// complex_nr_mult
// Signed complex multiply (a + jb)(c + jd) using one time-shared signed
// multiplier. The four partial products are formed on four consecutive
// cycles after operand acceptance and accumulated into:
//   res_re = a*c - b*d
//   res_im = a*d + b*c
//
// Ports:
//   clk      clock, all state updates on posedge
//   rstn     asynchronous active-low reset
//   sw_rst   synchronous active-high software reset
//   bus      complex_nr_mult_if.slave: operand and result handshakes
// ----------------------------------------------------------------------------
module complex_nr_mult #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   sw_rst,
    complex_nr_mult_if.slave       bus
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int RW = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        MUL_AC,
        MUL_BD,
        MUL_AD,
        MUL_BC,
        RESULT
    } state_t;

    state_t                  state_q, state_d;
    logic signed [DATA_WIDTH-1:0] a_q, a_d;
    logic signed [DATA_WIDTH-1:0] b_q, b_d;
    logic signed [DATA_WIDTH-1:0] c_q, c_d;
    logic signed [DATA_WIDTH-1:0] d_q, d_d;
    logic signed [RW-1:0]    acc_re_q, acc_re_d;
    logic signed [RW-1:0]    acc_im_q, acc_im_d;
    logic signed [RW-1:0]    res_re_q, res_re_d;
    logic signed [RW-1:0]    res_im_q, res_im_d;

    logic signed [DATA_WIDTH-1:0] mul_x, mul_y;
    logic signed [PW-1:0]    mul_x_ext, mul_y_ext;
    logic signed [PW-1:0]    product;
    logic signed [RW-1:0]    product_ext;

    // Operand selection for the shared multiplier; each compute state
    // picks the pair whose product it consumes this cycle.
    always_comb begin
        mul_x = a_q;
        mul_y = c_q;
        case (state_q)
            MUL_BD: begin
                mul_x = b_q;
                mul_y = d_q;
            end
            MUL_AD: begin
                mul_x = a_q;
                mul_y = d_q;
            end
            MUL_BC: begin
                mul_x = b_q;
                mul_y = c_q;
            end
            default: begin
                mul_x = a_q;
                mul_y = c_q;
            end
        endcase
    end

    // Operands are sign-extended to the full product width so the low
    // PW bits of the multiply are the exact signed product.
    assign mul_x_ext   = {{DATA_WIDTH{mul_x[DATA_WIDTH-1]}}, mul_x};
    assign mul_y_ext   = {{DATA_WIDTH{mul_y[DATA_WIDTH-1]}}, mul_y};
    assign product     = mul_x_ext * mul_y_ext;
    // One guard bit: (-2^(N-1))^2 + (-2^(N-1))^2 = 2^(2N-1) needs it.
    assign product_ext = {product[PW-1], product};

    // Next-state and datapath update. sw_rst overrides everything,
    // including a simultaneous operand or result handshake.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        res_re_d = res_re_q;
        res_im_d = res_im_q;

        if (sw_rst) begin
            state_d  = IDLE;
            a_d      = '0;
            b_d      = '0;
            c_d      = '0;
            d_d      = '0;
            acc_re_d = '0;
            acc_im_d = '0;
            res_re_d = '0;
            res_im_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.op_val) begin
                        a_d     = bus.op_1_re;
                        b_d     = bus.op_1_im;
                        c_d     = bus.op_2_re;
                        d_d     = bus.op_2_im;
                        state_d = MUL_AC;
                    end
                end
                MUL_AC: begin
                    acc_re_d = product_ext;
                    state_d  = MUL_BD;
                end
                MUL_BD: begin
                    acc_re_d = acc_re_q - product_ext;
                    state_d  = MUL_AD;
                end
                MUL_AD: begin
                    acc_im_d = product_ext;
                    state_d  = MUL_BC;
                end
                MUL_BC: begin
                    acc_im_d = acc_im_q + product_ext;
                    res_re_d = acc_re_q;
                    res_im_d = acc_im_q + product_ext;
                    state_d  = RESULT;
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register; rstn clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            res_re_q <= '0;
            res_im_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            res_re_q <= res_re_d;
            res_im_q <= res_im_d;
        end
    end

    // Handshake flags are pure state decodes, so they follow rstn at once.
    assign bus.op_ready = (state_q == IDLE);
    assign bus.res_val  = (state_q == RESULT);
    assign bus.res_re   = res_re_q;
    assign bus.res_im   = res_im_q;

endmodule

// File: tb/tb_complex_nr_mult.sv
// ----------------------------------------------------------------------------
// tb_complex_nr_mult
// Self-checking bench for complex_nr_mult. Expected results come from plain
// integer arithmetic on the operands; handshake timing is checked against
// the fixed four-cycle compute latency.
// ----------------------------------------------------------------------------
module tb_complex_nr_mult;
    localparam int DATA_WIDTH = 8;

    logic clk = 1'b0;
    logic rstn;
    logic sw_rst;
    int   checkCount = 0;
    int   passCount  = 0;

    complex_nr_mult_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    complex_nr_mult #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .sw_rst (sw_rst),
        .bus    (bus)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag,
                               input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Operand buses are don't-care outside the accepting edge
    task automatic scrambleOperands();
        bus.op_1_re = DATA_WIDTH'($urandom);
        bus.op_1_im = DATA_WIDTH'($urandom);
        bus.op_2_re = DATA_WIDTH'($urandom);
        bus.op_2_im = DATA_WIDTH'($urandom);
    endtask

    // One full transaction: present operands, keep op_val up for extraVal
    // edges after acceptance, wait for the result, stall readyDelay cycles,
    // then (optionally) take the result.
    task automatic applyStimulus(input int a, input int b, input int c, input int d,
                                 input int readyDelay, input int extraVal,
                                 input bit doTransfer);
        int waited;
        int edges;
        bit stableOk;
        bit seen;
        logic signed [2*DATA_WIDTH:0] expRe;
        logic signed [2*DATA_WIDTH:0] expIm;
        logic signed [2*DATA_WIDTH:0] heldRe;
        logic signed [2*DATA_WIDTH:0] heldIm;

        expRe = (2*DATA_WIDTH+1)'(a * c - b * d);
        expIm = (2*DATA_WIDTH+1)'(a * d + b * c);

        waited = 0;
        while (bus.op_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_accept", bus.op_ready, 1);

        bus.op_1_re = DATA_WIDTH'(a);
        bus.op_1_im = DATA_WIDTH'(b);
        bus.op_2_re = DATA_WIDTH'(c);
        bus.op_2_im = DATA_WIDTH'(d);
        bus.op_val  = 1'b1;
        @(posedge clk);

        edges = 0;
        seen  = 1'b0;
        while (!seen && edges <= 10) begin
            @(negedge clk);
            if (edges >= extraVal) begin
                bus.op_val = 1'b0;
                scrambleOperands();
            end
            if (edges == 0) checkOutput("ready_low_after_accept", bus.op_ready, 0);
            if (bus.res_val === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                edges++;
            end
        end
        checkOutput("latency", edges, 4);
        checkOutput("res_re", bus.res_re, expRe);
        checkOutput("res_im", bus.res_im, expIm);

        heldRe   = bus.res_re;
        heldIm   = bus.res_im;
        stableOk = 1'b1;
        for (int i = 0; i < readyDelay; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.res_val !== 1'b1 || bus.res_re !== heldRe ||
                bus.res_im !== heldIm || bus.op_ready !== 1'b0)
                stableOk = 1'b0;
        end
        if (readyDelay > 0) checkOutput("backpressure_stable", stableOk, 1);

        if (doTransfer) begin
            bus.res_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.res_ready = 1'b0;
            bus.op_val    = 1'b0;
            checkOutput("res_val_drop", bus.res_val, 0);
            checkOutput("ready_after_transfer", bus.op_ready, 1);
            checkOutput("res_re_held", bus.res_re, expRe);
            checkOutput("res_im_held", bus.res_im, expIm);
            @(posedge clk);
            @(negedge clk);
            checkOutput("no_second_capture", bus.op_ready, 1);
        end
    endtask

    initial begin
        bit sawVal;
        logic signed [DATA_WIDTH-1:0] ra, rb, rc, rd;

        rstn          = 1'b0;
        sw_rst        = 1'b0;
        bus.op_val    = 1'b0;
        bus.res_ready = 1'b0;
        scrambleOperands();
        repeat (3) @(negedge clk);

        checkOutput("reset_op_ready", bus.op_ready, 1);
        checkOutput("reset_res_val", bus.res_val, 0);
        checkOutput("reset_res_re", bus.res_re, 0);
        checkOutput("reset_res_im", bus.res_im, 0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rstn", bus.op_ready, 1);

        $display("[TB] directed values");
        applyStimulus(2, 3, 4, 2, 20, 1, 1'b1);
        applyStimulus(1, 1, 1, 1, 0, 0, 1'b1);
        applyStimulus(-128, -128, -128, -128, 0, 0, 1'b1);
        applyStimulus(127, -128, -128, 127, 0, 0, 1'b1);

        $display("[TB] backpressure with op_val held high");
        applyStimulus(-37, 91, 55, -12, 30, 1000, 1'b1);

        $display("[TB] software reset mid-compute");
        bus.op_1_re = 8'sd2;
        bus.op_1_im = 8'sd3;
        bus.op_2_re = 8'sd4;
        bus.op_2_im = 8'sd2;
        bus.op_val  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.op_val = 1'b0;
        scrambleOperands();
        @(posedge clk);
        @(negedge clk);
        sw_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sw_rst = 1'b0;
        checkOutput("sw_rst_op_ready", bus.op_ready, 1);
        checkOutput("sw_rst_res_val", bus.res_val, 0);
        checkOutput("sw_rst_res_re", bus.res_re, 0);
        checkOutput("sw_rst_res_im", bus.res_im, 0);
        sawVal = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.res_val !== 1'b0) sawVal = 1'b1;
        end
        checkOutput("no_result_after_sw_rst", sawVal, 0);
        applyStimulus(2, 3, 4, 2, 0, 0, 1'b1);

        $display("[TB] async reset while result pending");
        applyStimulus(5, -6, 7, 8, 2, 0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        checkOutput("rstn_res_val", bus.res_val, 0);
        checkOutput("rstn_res_re", bus.res_re, 0);
        checkOutput("rstn_res_im", bus.res_im, 0);
        checkOutput("rstn_op_ready", bus.op_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        applyStimulus(-9, 4, 11, -3, 1, 0, 1'b1);

        $display("[TB] random operands");
        for (int n = 0; n < 100; n++) begin
            ra = DATA_WIDTH'($urandom);
            rb = DATA_WIDTH'($urandom);
            rc = DATA_WIDTH'($urandom);
            rd = DATA_WIDTH'($urandom);
            applyStimulus(ra, rb, rc, rd, int'($urandom_range(0, 5)),
                          int'($urandom_range(0, 3)), 1'b1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
